// File: rtl/dec_trigger_ctl.sv
// Decode-stage trigger sequencer: chains and selects trigger matches, then holds a TLU request.
// Optional macro DEC_TRIG_CHAIN_EN enables trigger-pair chaining; when undefined, trigger_chain is ignored.
module dec_trigger_ctl #(
    parameter int ACK_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i0_trigger_match_d,
    input  logic [3:0] i1_trigger_match_d,
    input  logic       i0_valid_d,
    input  logic       i1_valid_d,
    input  logic [1:0] trigger_chain,
    input  logic [3:0] trigger_action,
    input  logic       dec_tlu_dbg_mode,
    input  logic       flush,
    input  logic       tlu_trig_ack,
    output logic       trig_req,
    output logic       trig_req_slot,
    output logic       trig_req_action,
    output logic [3:0] trig_hit,
    output logic [3:0] trig_hit_set,
    output logic       trig_stall,
    output logic       trig_timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        SETHIT = 2'd2
    } state_t;

    localparam bit              TO_EN   = (ACK_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [3:0]      hit_q, hit_d;
    logic            slot_q, slot_d;
    logic            act_q, act_d;
    logic            to_pulse;

    logic [3:0] eff0, eff1;
    logic       hit0, hit1;
    logic [3:0] sel_eff;
    logic       sel_act;
    logic       capture;
    logic       to_expire;

`ifdef DEC_TRIG_CHAIN_EN
    // A chained pair only fires when both members match; both bits then report it.
    function automatic logic [3:0] chain_fn(input logic [3:0] m, input logic [1:0] ch);
        logic [3:0] e;
        e = m;
        if (ch[0]) begin
            e[0] = m[0] & m[1];
            e[1] = m[0] & m[1];
        end
        if (ch[1]) begin
            e[2] = m[2] & m[3];
            e[3] = m[2] & m[3];
        end
        return e;
    endfunction

    assign eff0 = chain_fn(i0_trigger_match_d, trigger_chain);
    assign eff1 = chain_fn(i1_trigger_match_d, trigger_chain);
`else
    logic unused_chain;

    assign unused_chain = ^trigger_chain;
    assign eff0         = i0_trigger_match_d;
    assign eff1         = i1_trigger_match_d;
`endif

    assign hit0      = i0_valid_d & (|eff0);
    assign hit1      = i1_valid_d & (|eff1);
    assign sel_eff   = hit0 ? eff0 : eff1;
    assign sel_act   = |(sel_eff & trigger_action);
    assign capture   = (hit0 | hit1) & ~dec_tlu_dbg_mode & ~flush;
    assign to_expire = TO_EN && (cnt_q == TO_LAST);

    // Next-state, timeout counter and capture register update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hit_d    = hit_q;
        slot_d   = slot_q;
        act_d    = act_q;
        to_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (capture) begin
                    state_d = PEND;
                    hit_d   = sel_eff;
                    slot_d  = ~hit0;
                    act_d   = sel_act;
                end
            end
            PEND: begin
                cnt_d = cnt_q + 1'b1;
                if (tlu_trig_ack) begin
                    state_d = SETHIT;
                    cnt_d   = '0;
                end else if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    hit_d   = '0;
                    slot_d  = 1'b0;
                    act_d   = 1'b0;
                end else if (to_expire) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    hit_d    = '0;
                    slot_d   = 1'b0;
                    act_d    = 1'b0;
                    to_pulse = 1'b1;
                end
            end
            SETHIT: begin
                state_d = IDLE;
                cnt_d   = '0;
                hit_d   = '0;
                slot_d  = 1'b0;
                act_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                hit_d   = '0;
                slot_d  = 1'b0;
                act_d   = 1'b0;
            end
        endcase
    end

    // State, counter and captured request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hit_q   <= '0;
            slot_q  <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            slot_q  <= slot_d;
            act_q   <= act_d;
        end
    end

    assign trig_req        = (state_q == PEND);
    assign trig_stall      = (state_q != IDLE);
    assign trig_req_slot   = slot_q;
    assign trig_req_action = act_q;
    assign trig_hit        = hit_q;
    assign trig_hit_set    = (state_q == SETHIT) ? hit_q : 4'b0000;
    assign trig_timeout    = to_pulse & ~rst;

endmodule

// File: tb/tb_dec_trigger_ctl.sv
// Scoreboard bench for dec_trigger_ctl: reference model predicts request, hit-set and timeout events.
// Honours DEC_TRIG_CHAIN_EN the same way the design does.
module tb_dec_trigger_ctl;

    localparam int TO = 15;

    localparam int K_REQ = 0;
    localparam int K_SET = 1;
    localparam int K_TO  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] i0_trigger_match_d, i1_trigger_match_d;
    logic       i0_valid_d, i1_valid_d;
    logic [1:0] trigger_chain;
    logic [3:0] trigger_action;
    logic       dec_tlu_dbg_mode, flush, tlu_trig_ack;
    logic       trig_req, trig_req_slot, trig_req_action;
    logic [3:0] trig_hit, trig_hit_set;
    logic       trig_stall, trig_timeout;

    dec_trigger_ctl #(.ACK_TIMEOUT(TO), .TO_W(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .i0_trigger_match_d (i0_trigger_match_d),
        .i1_trigger_match_d (i1_trigger_match_d),
        .i0_valid_d         (i0_valid_d),
        .i1_valid_d         (i1_valid_d),
        .trigger_chain      (trigger_chain),
        .trigger_action     (trigger_action),
        .dec_tlu_dbg_mode   (dec_tlu_dbg_mode),
        .flush              (flush),
        .tlu_trig_ack       (tlu_trig_ack),
        .trig_req           (trig_req),
        .trig_req_slot      (trig_req_slot),
        .trig_req_action    (trig_req_action),
        .trig_hit           (trig_hit),
        .trig_hit_set       (trig_hit_set),
        .trig_stall         (trig_stall),
        .trig_timeout       (trig_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       kind;
        logic [3:0] hit;
        logic     slot;
        logic     act;
        int       due;
    } ev_t;

    ev_t q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc    = 0;
    bit  chk_en = 1'b0;

    // Reference model state: phase 0 = no request, 1 = waiting for TLU, 2 = hit-set cycle.
    int       m_phase = 0;
    int       m_age   = 0;
    logic [3:0] m_hit;
    bit       m_busy  = 1'b0;
    bit       m_req   = 1'b0;

    function automatic logic [3:0] eff_of(input logic [3:0] m);
        logic [3:0] e;
        e = m;
`ifdef DEC_TRIG_CHAIN_EN
        for (int p = 0; p < 2; p++) begin
            if (trigger_chain[p]) begin
                e[2*p]   = m[2*p] && m[2*p+1];
                e[2*p+1] = m[2*p] && m[2*p+1];
            end
        end
`endif
        return e;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Model: decide this cycle's behaviour from the inputs the DUT will sample next edge.
    always @(negedge clk) begin
        logic [3:0] e0, e1, sel;
        bit h0, h1;
        ev_t ev;
        cyc++;
        m_busy = (m_phase != 0);
        m_req  = (m_phase == 1);
        if (rst) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            e0 = eff_of(i0_trigger_match_d);
            e1 = eff_of(i1_trigger_match_d);
            h0 = i0_valid_d && (e0 != 0);
            h1 = i1_valid_d && (e1 != 0);
            if ((h0 || h1) && !dec_tlu_dbg_mode && !flush) begin
                sel      = h0 ? e0 : e1;
                ev.kind  = K_REQ;
                ev.hit   = sel;
                ev.slot  = !h0;
                ev.act   = (sel & trigger_action) != 0;
                ev.due   = cyc + 1;
                q.push_back(ev);
                m_hit   = sel;
                m_phase = 1;
                m_age   = 1;
            end
        end else if (m_phase == 1) begin
            if (tlu_trig_ack) begin
                ev.kind = K_SET;
                ev.hit  = m_hit;
                ev.slot = 1'b0;
                ev.act  = 1'b0;
                ev.due  = cyc + 1;
                q.push_back(ev);
                m_phase = 2;
            end else if (flush) begin
                m_phase = 0;
            end else if (TO != 0 && m_age == TO) begin
                ev.kind = K_TO;
                ev.hit  = 4'b0000;
                ev.slot = 1'b0;
                ev.act  = 1'b0;
                ev.due  = cyc;
                q.push_back(ev);
                m_phase = 0;
            end else begin
                m_age++;
            end
        end else begin
            m_phase = 0;
        end
    end

    logic       req_prev = 1'b0;
    logic [3:0] held_hit;
    logic       held_slot, held_act;

    task automatic take(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event kind=%0d at cycle %0d: got event expected none", kind, cyc);
            return;
        end
        e = q.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.due);
        if (kind == K_REQ) begin
            chk("req_hit", trig_hit, e.hit);
            chk("req_slot", trig_req_slot, e.slot);
            chk("req_action", trig_req_action, e.act);
            held_hit  = e.hit;
            held_slot = e.slot;
            held_act  = e.act;
        end else if (kind == K_SET) begin
            chk("hit_set", trig_hit_set, e.hit);
        end
    endtask

    // Monitor: compares DUT events against the scoreboard queue, away from the clock edge.
    always begin
        bit got_req;
        @(negedge clk);
        #1;
        got_req = (trig_req === 1'b1) && (req_prev !== 1'b1);
        if (chk_en) begin
            chk("stall", trig_stall, m_busy);
            chk("req", trig_req, m_req);
            if (!m_busy)
                chk("idle_outputs", {trig_hit, trig_req_slot, trig_req_action, trig_hit_set}, 0);
            if (got_req) take(K_REQ);
            else if (trig_req === 1'b1)
                chk("held_capture", {trig_hit, trig_req_slot, trig_req_action},
                    {held_hit, held_slot, held_act});
            if (trig_hit_set !== 4'b0000) take(K_SET);
            if (trig_timeout !== 1'b0) take(K_TO);
            while (q.size() != 0 && q[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_event kind=%0d at cycle %0d: got none expected due %0d",
                         q[0].kind, cyc, q[0].due);
                void'(q.pop_front());
            end
        end
        req_prev = trig_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        i0_trigger_match_d = 4'b0000;
        i1_trigger_match_d = 4'b0000;
        i0_valid_d         = 1'b0;
        i1_valid_d         = 1'b0;
        dec_tlu_dbg_mode   = 1'b0;
        flush              = 1'b0;
        tlu_trig_ack       = 1'b0;
    endtask

    task automatic fire0(input logic [3:0] m);
        i0_valid_d         = 1'b1;
        i0_trigger_match_d = m;
        tick();
        clr();
    endtask

    task automatic ack_after(input int n);
        repeat (n) tick();
        tlu_trig_ack = 1'b1;
        tick();
        clr();
        repeat (2) tick();
    endtask

    initial begin
        int ackp;
        rst            = 1'b1;
        trigger_chain  = 2'b00;
        trigger_action = 4'b0000;
        clr();
        tick();
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // single i0 hit acknowledged after three pending cycles
        trigger_action = 4'b0100;
        fire0(4'b0100);
        ack_after(2);

        // i1 only, then both slots with i0 priority
        trigger_action = 4'b0000;
        i1_valid_d = 1'b1;
        i1_trigger_match_d = 4'b0001;
        tick();
        clr();
        ack_after(1);
        i0_valid_d = 1'b1;
        i1_valid_d = 1'b1;
        i0_trigger_match_d = 4'b1000;
        i1_trigger_match_d = 4'b0001;
        tick();
        clr();
        ack_after(1);

        // chained pair 0/1
        trigger_chain = 2'b01;
        fire0(4'b0001);
        ack_after(1);
        fire0(4'b0011);
        ack_after(1);
        trigger_chain = 2'b00;

        // timeout with no ack
        fire0(4'b0010);
        repeat (20) tick();

        // flush drop, then flush together with ack
        fire0(4'b0010);
        tick();
        flush = 1'b1;
        tick();
        clr();
        tick();
        fire0(4'b0100);
        flush = 1'b1;
        tlu_trig_ack = 1'b1;
        tick();
        clr();
        repeat (2) tick();

        // debug mode blocks capture; debug mode during a pending request does not cancel it
        dec_tlu_dbg_mode = 1'b1;
        i0_valid_d = 1'b1;
        i0_trigger_match_d = 4'b1111;
        tick();
        clr();
        tick();
        fire0(4'b1000);
        dec_tlu_dbg_mode = 1'b1;
        tick();
        dec_tlu_dbg_mode = 1'b0;
        ack_after(1);

        // reset in the middle of a pending request
        fire0(4'b0001);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // randomized traffic, with some ack-free stretches so timeouts occur
        for (int b = 0; b < 30; b++) begin
            ackp = ($urandom_range(0, 2) == 0) ? 0 : 5;
            for (int i = 0; i < 100; i++) begin
                i0_valid_d         = 1'($urandom);
                i1_valid_d         = 1'($urandom);
                i0_trigger_match_d = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
                i1_trigger_match_d = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
                trigger_chain      = 2'($urandom);
                trigger_action     = 4'($urandom);
                dec_tlu_dbg_mode   = ($urandom_range(0, 7) == 0);
                flush              = ($urandom_range(0, 11) == 0);
                tlu_trig_ack       = (ackp != 0) && ($urandom_range(0, ackp) == 0);
                rst                = ($urandom_range(0, 299) == 0);
                tick();
            end
        end
        clr();
        rst = 1'b0;
        repeat (20) tick();
        tlu_trig_ack = 1'b1;
        tick();
        clr();
        repeat (3) tick();

        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dec_trigger_ctl.md
Name: dec_trigger_ctl

Overview:
Sequencer for the decode-stage trigger match results.
- Takes raw per-trigger PC-match vectors for i0 and i1.
- Applies trigger-pair chaining and picks one winning slot.
- Holds a registered trigger request to the TLU until it is acknowledged, flushed or timed out.
- Stalls decode while a request is outstanding and issues a one-cycle hit-bit set pulse to the trigger CSRs.

Parameters:
ACK_TIMEOUT, 15, cycles in PEND without ack before the request is dropped; 0 disables the timeout.
TO_W, 4, width of timeout counter; must satisfy 2^TO_W > ACK_TIMEOUT.

Ports:
clk  in  1  core clock
rst  in  1  reset
i0_trigger_match_d  in  4  raw per-trigger match, slot i0
i1_trigger_match_d  in  4  raw per-trigger match, slot i1
i0_valid_d  in  1  i0 instruction valid in decode
i1_valid_d  in  1  i1 instruction valid in decode
trigger_chain  in  2  [0]: triggers 0/1 chained; [1]: triggers 2/3 chained
trigger_action  in  4  per trigger: 1 = enter debug mode, 0 = breakpoint exception
dec_tlu_dbg_mode  in  1  core in debug mode; suppresses capture
flush  in  1  pipeline flush
tlu_trig_ack  in  1  TLU accepts pending request
trig_req  out  1  request pending to TLU
trig_req_slot  out  1  0 = i0, 1 = i1
trig_req_action  out  1  1 = debug mode, 0 = breakpoint
trig_hit  out  4  effective match vector of captured slot
trig_hit_set  out  4  one-cycle pulse; sets tdata1 hit bits
trig_stall  out  1  decode stall
trig_timeout  out  1  one-cycle pulse on timeout drop

Behaviour:
- Reset: one clock (clk); reset is synchronous and active-high (rst). While rst=1: state IDLE, counter 0, all outputs 0.
- Chaining, per slot, combinational, on unregistered inputs:
  - pair (0,1), chain[0]=1: eff[0]=eff[1]=m[0]&m[1]; otherwise eff=m.
  - pair (2,3) with chain[1] is handled the same way.
- Slot selection: hit0 = i0_valid_d & |eff_i0; hit1 = i1_valid_d & |eff_i1.
  - hit0 selects i0; otherwise hit1 selects i1. i0 always has priority.
  - Action = OR of trigger_action[k] over set bits of the selected eff vector.
- State machine, states IDLE, PEND, SETHIT:
  - IDLE -> PEND when (hit0|hit1) & ~dec_tlu_dbg_mode & ~flush. The same edge registers trig_hit, trig_req_slot and trig_req_action. Latency: match in cycle N gives trig_req=1 in cycle N+1.
  - PEND:
    - trig_req=1 and trig_stall=1; captured outputs are held constant.
    - Counter increments each PEND cycle and resets to 0 on leaving PEND.
    - tlu_trig_ack -> SETHIT. Ack has priority over flush and timeout in the same cycle.
    - Else flush -> IDLE; no hit set, no timeout pulse.
    - Else, if ACK_TIMEOUT!=0 and counter==ACK_TIMEOUT-1 -> IDLE, with trig_timeout=1 for that cycle.
  - SETHIT (exactly 1 cycle):
    - trig_hit_set = trig_hit; trig_req=0; trig_stall=1.
    - New matches are ignored this cycle.
    - Always -> IDLE.
- On every exit to IDLE, trig_hit, trig_req_slot and trig_req_action clear to 0.
- trig_req and trig_stall are 0 in IDLE. trig_stall = (state != IDLE).
- tlu_trig_ack in IDLE or SETHIT is ignored.
- dec_tlu_dbg_mode rising during PEND does not cancel the request; it only blocks new captures.
- Counter saturation is impossible given the TO_W constraint. With ACK_TIMEOUT=0 the counter may wrap harmlessly.

Optional Feature:
DEC_TRIG_CHAIN_EN.
- Defined: chaining as described above.
- Undefined: trigger_chain is ignored (treated as 2'b00), eff = raw match, and no chaining logic is synthesized.

Test Plan:
- i0_valid=1, i0 match=4'b0100, action[2]=1 -> next cycle trig_req=1, slot=0, action=1, trig_hit=4'b0100, stall=1. Ack 3 cycles later -> trig_hit_set=4'b0100 for one cycle, then IDLE with all outputs 0.
- i0_valid=0, i1_valid=1, i1 match=4'b0001; then both valid, i0=4'b1000, i1=4'b0001 -> slot=1 in the first case, slot=0 with trig_hit=4'b1000 in the second.
- Chain=2'b01 with DEC_TRIG_CHAIN_EN: i0 match=4'b0001 -> no request; i0 match=4'b0011 -> trig_hit=4'b0011. Same stimulus without the macro -> trig_hit=4'b0001 and 4'b0011 respectively.
- PEND, no ack, ACK_TIMEOUT=15 -> trig_timeout pulses in the 15th PEND cycle, next state IDLE, trig_hit_set never asserts.
- PEND with flush=1 and ack=0 -> IDLE next cycle, no hit set. PEND with flush=1 and ack=1 in the same cycle -> SETHIT.
- dec_tlu_dbg_mode=1 with i0 match=4'b1111 -> no request. rst=1 asserted mid-PEND -> next cycle all outputs 0, state IDLE.
